axis_stream_checker: RTL

//  AXI-Stream slave sink that consumes the stream produced by the generator/FIFO chain.

---
 rtl/axis_stream_checker_pkg.sv | 16 +
 rtl/axis_stream_checker_if.sv | 13 +
 rtl/axis_stream_checker_ready_throttle.sv | 33 +++
 rtl/axis_stream_checker.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/axis_stream_checker_pkg.sv
// Shared definitions for the AXI-Stream checker: FSM encodings and small decode helpers.
// Imported by the checker top and its sub-module.
package axis_stream_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // True when the given beat index is the one that must carry tlast.
    function automatic logic is_last_beat(input int idx, input int pkt_len);
        return (idx == (pkt_len - 1));
    endfunction

endpackage

// File: rtl/axis_stream_checker_if.sv
// AXI-Stream handshake bundle between a stream source (master) and the checker (slave).
interface axis_stream_checker_if #(
    parameter int DATA_SIZE = 32
);
    logic [DATA_SIZE-1:0]   tdata;
    logic [DATA_SIZE/8-1:0] tstrb;
    logic                   tvalid;
    logic                   tlast;
    logic                   tready;

    modport master (output tdata, output tstrb, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tstrb, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_stream_checker_ready_throttle.sv
// tready throttle: free-running phase counter that requests one stall cycle in every
// STALL_PERIOD while the checker is active; STALL_PERIOD=0 never stalls.
module axis_ready_throttle #(
    parameter int STALL_PERIOD = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic stall
);
    localparam int CW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [CW-1:0] LAST_PHASE = CW'((STALL_PERIOD > 0) ? (STALL_PERIOD - 1) : 0);

    logic [CW-1:0] thr_cnt_r;

    // Phase counter; holds its value while the checker is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_cnt_r <= '0;
        end else if (run) begin
            if (thr_cnt_r == LAST_PHASE) begin
                thr_cnt_r <= '0;
            end else begin
                thr_cnt_r <= thr_cnt_r + CW'(1);
            end
        end else begin
            thr_cnt_r <= thr_cnt_r;
        end
    end

    assign stall = (STALL_PERIOD != 0) && (thr_cnt_r == LAST_PHASE);

endmodule

// File: rtl/axis_stream_checker.sv
// AXI-Stream sink that throttles tready, checks incrementing data, tlast placement and
// full strobes on every accepted beat, and keeps saturating statistics plus sticky flags.
module axis_stream_checker
    import axis_stream_checker_pkg::*;
#(
    parameter int DATA_SIZE    = 32,
    parameter int PKT_LEN      = 16,
    parameter int STALL_PERIOD = 0,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  s00_axis_aclk,
    input  logic                  s00_axis_areset,
    input  logic                  s00_axis_enable,
    axis_stream_checker_if.slave  s00_axis,
    input  logic                  clear_stats,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  data_err,
    output logic                  last_err,
    output logic                  strb_err
);
    localparam int IDX_W = $clog2(PKT_LEN);
    localparam logic [DATA_SIZE/8-1:0] STRB_ALL = {(DATA_SIZE/8){1'b1}};
    localparam logic [CNT_WIDTH-1:0]   CNT_MAX  = {CNT_WIDTH{1'b1}};

    state_e               state_r, state_nxt_s;
    logic                 stall_s, run_s, tready_s, xfer_s;
    logic                 data_err_s, last_err_s, strb_err_s, any_err_s, idx_last_s;
    logic [DATA_SIZE-1:0] exp_data_r;
    logic [IDX_W-1:0]     beat_idx_r;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : (v + CNT_WIDTH'(1));
    endfunction

    assign run_s = (state_r != ST_IDLE);

    axis_ready_throttle #(.STALL_PERIOD(STALL_PERIOD)) u_throttle (
        .clk   (s00_axis_aclk),
        .rst   (s00_axis_areset),
        .run   (run_s),
        .stall (stall_s)
    );

    assign xfer_s     = s00_axis.tvalid & tready_s;
    assign idx_last_s = is_last_beat(int'(beat_idx_r), PKT_LEN);
    assign data_err_s = (s00_axis.tdata != exp_data_r);
    assign last_err_s = (s00_axis.tlast != idx_last_s);
    assign strb_err_s = (s00_axis.tstrb != STRB_ALL);
    assign any_err_s  = data_err_s | last_err_s | strb_err_s;

    // FSM state register.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: a disable mid-packet drains to the next tlast before idling.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (s00_axis_enable) state_nxt_s = ST_RUN;
                else                 state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (s00_axis_enable)                 state_nxt_s = ST_RUN;
                else if (beat_idx_r != IDX_W'(0))    state_nxt_s = ST_DRAIN;
                else                                 state_nxt_s = ST_IDLE;
            end
            ST_DRAIN: begin
                if (s00_axis_enable)                 state_nxt_s = ST_RUN;
                else if (xfer_s && s00_axis.tlast)   state_nxt_s = ST_IDLE;
                else                                 state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: tready depends only on registered state and throttle phase.
    always_comb begin
        tready_s = 1'b0;
        if (run_s && !stall_s) tready_s = 1'b1;
        else                   tready_s = 1'b0;
    end

    assign s00_axis.tready = tready_s;

    // Expected data resyncs to the received beat so a single bad value flags only once.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            exp_data_r <= '0;
            beat_idx_r <= '0;
        end else if (xfer_s) begin
            exp_data_r <= s00_axis.tdata + DATA_SIZE'(1);
            if (s00_axis.tlast || idx_last_s) beat_idx_r <= '0;
            else                              beat_idx_r <= beat_idx_r + IDX_W'(1);
        end else begin
            exp_data_r <= exp_data_r;
            beat_idx_r <= beat_idx_r;
        end
    end

    // Statistics and sticky flags; a clear drops any same-cycle beat's contribution.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            beat_count <= '0;
            pkt_count  <= '0;
            err_count  <= '0;
            data_err   <= 1'b0;
            last_err   <= 1'b0;
            strb_err   <= 1'b0;
        end else if (clear_stats) begin
            beat_count <= '0;
            pkt_count  <= '0;
            err_count  <= '0;
            data_err   <= 1'b0;
            last_err   <= 1'b0;
            strb_err   <= 1'b0;
        end else if (xfer_s) begin
            beat_count <= sat_inc(beat_count);
            pkt_count  <= s00_axis.tlast ? sat_inc(pkt_count) : pkt_count;
            err_count  <= any_err_s ? sat_inc(err_count) : err_count;
            data_err   <= data_err | data_err_s;
            last_err   <= last_err | last_err_s;
            strb_err   <= strb_err | strb_err_s;
        end else begin
            beat_count <= beat_count;
            pkt_count  <= pkt_count;
            err_count  <= err_count;
            data_err   <= data_err;
            last_err   <= last_err;
            strb_err   <= strb_err;
        end
    end

endmodule
